lifo_pop_adapter: RTL and testbench

- Reader-side companion to the `lifo` block: owns `rd_en` and `data_rd`/`lifo_empty`.
- On command, pops up to N entries and presents them in LIFO order as a valid/ready stream, with `out_last` on the final word.
- Absorbs the LIFO's 1-cycle registered read latency with a 2-entry output buffer, so downstream back-pressure never loses data.
- Sits between a `lifo` instance and any stream consumer (DMA, serializer).

---
 rtl/lifo_pkg.sv | 24 ++
 rtl/lifo_pop_skid_buf.sv | 66 ++++++
 rtl/lifo_pop_adapter.sv | 163 ++++++++++++++++
 tb/tb_lifo_pop_adapter.sv | 352 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lifo_pkg.sv
`default_nettype none
// ============================================================================
// Module : lifo_pkg
// Purpose: Shared definitions for the LIFO pop adapter slice: drain FSM state
//          encoding, default data width and the count-field width helper.
// Rev    : 1.0  initial release
// ============================================================================
package lifo_pkg;

  localparam int DEFAULT_DATA_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    POP   = 2'd1,
    FLUSH = 2'd2
  } state_t;

  // Width needed to hold any request count from 0 up to max_count inclusive.
  function automatic int cnt_width(input int max_count);
    return $clog2(max_count + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/lifo_pop_skid_buf.sv
`default_nettype none
// ============================================================================
// Module : lifo_pop_skid_buf
// Purpose: 2-entry FIFO that catches words returned by the LIFO so that
//          downstream back-pressure never drops data.
// Ports  : clk, rst        - clock, synchronous active-high reset
//          wr_en, wr_data  - write one word at the tail
//          rd_en           - pop the head word
//          head_data       - current head word
//          occupancy       - number of stored words, 0..2
// Rev    : 1.0  initial release
// ============================================================================
module lifo_pop_skid_buf
  import lifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] head_data,
  output logic [1:0]            occupancy
);

  logic [DATA_WIDTH-1:0] mem [2];
  logic                  wr_ptr;
  logic                  rd_ptr;
  logic [1:0]            occ;
  logic                  do_rd;
  logic                  do_wr;

  // A write into a full buffer is only allowed when the head leaves the
  // same cycle; the adapter's credit check never asks for more.
  assign do_rd = rd_en && (occ != 2'd0);
  assign do_wr = wr_en && ((occ != 2'd2) || do_rd);

  always_ff @(posedge clk) begin
    if (rst) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      occ    <= 2'd0;
    end else begin
      if (do_wr) begin
        mem[wr_ptr] <= wr_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (do_rd) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({do_wr, do_rd})
        2'b10:   occ <= occ + 2'd1;
        2'b01:   occ <= occ - 2'd1;
        default: occ <= occ;
      endcase
    end
  end

  assign head_data = mem[rd_ptr];
  assign occupancy = occ;

endmodule
`default_nettype wire

// File: rtl/lifo_pop_adapter.sv
`default_nettype none
// ============================================================================
// Module : lifo_pop_adapter
// Purpose: Reader-side companion to a LIFO. On a drain command it pops up to
//          drain_count words and presents them, in LIFO order, as a
//          valid/ready stream with out_last on the final word.
// Ports  : clk, rst                  - clock, synchronous active-high reset
//          drain_start, drain_count  - command pulse and requested word count
//          busy, drain_done, drain_short - command status
//          lifo_rd_en, lifo_data_rd, lifo_empty - LIFO read side
//          out_data, out_valid, out_ready, out_last - output stream
// Config : LIFO_POP_ADAPTER_WAIT_EN - when defined, an empty LIFO stalls the
//          drain instead of ending it early (drain_short is then always 0).
// Rev    : 1.0  initial release
// ============================================================================
module lifo_pop_adapter
  import lifo_pkg::*;
#(
  parameter  int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter  int MAX_COUNT  = 16,
  localparam int CNT_W      = cnt_width(MAX_COUNT)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  drain_start,
  input  logic [CNT_W-1:0]      drain_count,
  output logic                  busy,
  output logic                  drain_done,
  output logic                  drain_short,
  output logic                  lifo_rd_en,
  input  logic [DATA_WIDTH-1:0] lifo_data_rd,
  input  logic                  lifo_empty,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_last
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t                state_q;
  state_t                state_d;
  logic [CNT_W-1:0]      remaining_q;
  logic                  inflight_q;
  logic                  short_q;
  logic                  done_d;
  logic                  short_d;

  logic [DATA_WIDTH-1:0] head_data;
  logic [1:0]            occ;
  logic [1:0]            held;
  logic                  pop_issue;
  logic                  underrun;
  logic                  bypass_take;
  logic                  buf_wr;
  logic                  buf_rd;
  logic                  drained;
  logic                  no_more_pops;

  // Words either stored or on their way back from the LIFO.
  assign held = occ + {1'b0, inflight_q};

  assign pop_issue = (state_q == POP) && (remaining_q != '0) && !lifo_empty &&
                     (held < 2'd2);

`ifdef LIFO_POP_ADAPTER_WAIT_EN
  assign underrun = 1'b0;
`else
  assign underrun = (state_q == POP) && (remaining_q != '0) && lifo_empty;
`endif

  // With an empty buffer the returning word is shown straight from the LIFO
  // read port; this is what gives first valid one cycle after the first pop.
  // It only enters the buffer if the consumer does not take it right away.
  assign bypass_take = inflight_q && (occ == 2'd0) && out_ready;
  assign buf_wr      = inflight_q && !bypass_take;
  assign buf_rd      = (occ != 2'd0) && out_ready;

  assign out_valid = (occ != 2'd0) || inflight_q;
  assign out_data  = (occ != 2'd0) ? head_data :
                     (inflight_q   ? lifo_data_rd : '0);

  // The visible word is the last one when it is the only word held and the
  // drain can no longer issue pops (count exhausted or underrun this cycle).
  assign no_more_pops = (state_q == FLUSH) ||
                        ((state_q == POP) && ((remaining_q == '0) || underrun));
  assign out_last     = out_valid && (held == 2'd1) && no_more_pops;

  assign drained    = (occ == 2'd0) && !inflight_q;
  assign busy       = (state_q != IDLE);
  assign lifo_rd_en = pop_issue;

  lifo_pop_skid_buf #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_buf (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (buf_wr),
    .wr_data   (lifo_data_rd),
    .rd_en     (buf_rd),
    .head_data (head_data),
    .occupancy (occ)
  );

  always_comb begin
    state_d = state_q;
    done_d  = 1'b0;
    short_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (drain_start) begin
          if (drain_count != '0) begin
            state_d = POP;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      POP: begin
        if (underrun || (pop_issue && (remaining_q == CNT_ONE))) begin
          state_d = FLUSH;
        end
      end
      FLUSH: begin
        if (drained) begin
          state_d = IDLE;
          done_d  = 1'b1;
          short_d = short_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      remaining_q <= '0;
      inflight_q  <= 1'b0;
      short_q     <= 1'b0;
      drain_done  <= 1'b0;
      drain_short <= 1'b0;
    end else begin
      state_q     <= state_d;
      inflight_q  <= pop_issue;
      drain_done  <= done_d;
      drain_short <= short_d;
      if ((state_q == IDLE) && drain_start) begin
        remaining_q <= drain_count;
        short_q     <= 1'b0;
      end else begin
        if (pop_issue) begin
          remaining_q <= remaining_q - CNT_ONE;
        end
        if (underrun) begin
          short_q <= 1'b1;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_lifo_pop_adapter.sv
`default_nettype none
// ============================================================================
// Module : tb_lifo_pop_adapter
// Purpose: Self-checking bench for lifo_pop_adapter with a behavioural LIFO
//          and a stack-based reference of which words a drain must return.
// Rev    : 1.0  initial release
// ============================================================================
module tb_lifo_pop_adapter;

  localparam int DW   = 8;
  localparam int MAXC = 16;
  localparam int CW   = $clog2(MAXC + 1);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          drain_start = 1'b0;
  logic [CW-1:0] drain_count = '0;
  logic          busy;
  logic          drain_done;
  logic          drain_short;
  logic          lifo_rd_en;
  logic [DW-1:0] lifo_data_rd = '0;
  logic          lifo_empty = 1'b1;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic          out_last;

  always #5 clk = ~clk;

  lifo_pop_adapter #(
    .DATA_WIDTH (DW),
    .MAX_COUNT  (MAXC)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .drain_start  (drain_start),
    .drain_count  (drain_count),
    .busy         (busy),
    .drain_done   (drain_done),
    .drain_short  (drain_short),
    .lifo_rd_en   (lifo_rd_en),
    .lifo_data_rd (lifo_data_rd),
    .lifo_empty   (lifo_empty),
    .out_data     (out_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_last     (out_last)
  );

  int pass_cnt = 0;
  int fail_cnt = 0;
  int total    = 0;

  // Behavioural LIFO contents and the reference stack used for expectations.
  logic [DW-1:0] stk[$];
  logic [DW-1:0] ref_stk[$];
  int            push_n = 0;
  logic [DW-1:0] push_a = '0;
  logic [DW-1:0] push_b = '0;

  // Monitor state.
  logic [DW-1:0] got_d[$];
  bit            got_l[$];
  bit            stall_prev = 1'b0;
  logic [DW-1:0] held_data = '0;
  bit            rd_smp = 1'b0;
  int            cyc = 0;
  int            t0 = 0;
  int            pops = 0;
  int            acc = 0;
  int            done_cnt = 0;
  int            done_cyc = -1;
  int            first_rden = -1;
  int            first_valid = -1;
  int            first_acc = -1;
  int            last_acc = -1;
  logic          last_short = 1'b0;
  int            ready_mode = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: observe at the falling edge, then update the LIFO model
  // and the consumer's ready just after the rising edge.
  task automatic tick();
    @(negedge clk);
    if (!rst) begin
      if (stall_prev) begin
        chk("hold_valid", 32'(out_valid), 32'd1);
        chk("hold_data", 32'(out_data), 32'(held_data));
      end
      stall_prev = out_valid && !out_ready;
      held_data  = out_data;
      if (lifo_rd_en) begin
        chk("pop_while_empty", 32'(lifo_empty), 32'd0);
        pops++;
        if (first_rden < 0) first_rden = cyc;
      end
      if (out_valid && first_valid < 0) first_valid = cyc;
      if (out_valid && out_ready) begin
        got_d.push_back(out_data);
        got_l.push_back(out_last);
        acc++;
        if (first_acc < 0) first_acc = cyc;
        last_acc = cyc;
      end
      if (lifo_rd_en) chk("credit", 32'(pops - acc <= 2), 32'd1);
      if (drain_done) begin
        done_cnt++;
        done_cyc   = cyc;
        last_short = drain_short;
      end
    end else begin
      stall_prev = 1'b0;
    end
    rd_smp = lifo_rd_en;
    @(posedge clk);
    #1;
    cyc++;
    if (rd_smp && stk.size() > 0) lifo_data_rd = stk.pop_back();
    if (push_n > 0) stk.push_back(push_a);
    if (push_n > 1) stk.push_back(push_b);
    push_n     = 0;
    lifo_empty = (stk.size() == 0);
    case (ready_mode)
      1:       out_ready = ~out_ready;
      2:       out_ready = 1'($urandom_range(0, 1));
      3:       out_ready = 1'b0;
      default: out_ready = 1'b1;
    endcase
  endtask

  task automatic push1(input logic [DW-1:0] v);
    push_n = 1;
    push_a = v;
    ref_stk.push_back(v);
    tick();
  endtask

  task automatic push2(input logic [DW-1:0] a, input logic [DW-1:0] b);
    push_n = 2;
    push_a = a;
    push_b = b;
    ref_stk.push_back(a);
    ref_stk.push_back(b);
    tick();
  endtask

  task automatic start_drain(input int n);
    got_d.delete();
    got_l.delete();
    pops        = 0;
    acc         = 0;
    done_cnt    = 0;
    done_cyc    = -1;
    first_rden  = -1;
    first_valid = -1;
    first_acc   = -1;
    last_acc    = -1;
    drain_start = 1'b1;
    drain_count = CW'(n);
    t0          = cyc;
    tick();
    drain_start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int w = 0;
    while (done_cnt == 0 && w < budget) begin
      tick();
      w++;
    end
    chk("done_seen", 32'(done_cnt > 0), 32'd1);
  endtask

  // Expected result of a drain: the top min(n, depth) words of the stack in
  // pop order, last flag on the final one, short when the stack ran out.
  task automatic check_drain(input string tag, input int n);
    int            avail;
    int            k;
    bit            exp_short;
    logic [DW-1:0] exp_d;
    avail = ref_stk.size();
`ifdef LIFO_POP_ADAPTER_WAIT_EN
    k         = n;
    exp_short = 1'b0;
`else
    k         = (n < avail) ? n : avail;
    exp_short = (n > avail);
`endif
    chk({tag, "_words"}, 32'(got_d.size()), 32'(k));
    for (int i = 0; i < k; i++) begin
      exp_d = ref_stk.pop_back();
      if (i < got_d.size()) begin
        chk($sformatf("%s_data%0d", tag, i), 32'(got_d[i]), 32'(exp_d));
        chk($sformatf("%s_last%0d", tag, i), 32'(got_l[i]), 32'(i == k - 1));
      end
    end
    chk({tag, "_short"}, 32'(last_short), 32'(exp_short));
    chk({tag, "_done_once"}, 32'(done_cnt), 32'd1);
  endtask

  initial begin
    // Reset values.
    rst = 1'b1;
    repeat (2) tick();
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_last", 32'(out_last), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_rd_en", 32'(lifo_rd_en), 32'd0);
    chk("rst_done", 32'(drain_done), 32'd0);
    chk("rst_short", 32'(drain_short), 32'd0);
    rst = 1'b0;
    tick();

    // Full-rate drain of three words.
    ready_mode = 0;
    push1(8'd10);
    push1(8'd20);
    push1(8'd30);
    start_drain(3);
    chk("basic_busy", 32'(busy), 32'd1);
    wait_done(200);
    chk("basic_first_pop", 32'(first_rden - t0), 32'd1);
    chk("basic_first_valid", 32'(first_valid - t0), 32'd2);
    chk("basic_back_to_back", 32'(last_acc - first_acc), 32'd2);
    chk("basic_lifo_empty", 32'(lifo_empty), 32'd1);
    check_drain("basic", 3);

    // Alternating back-pressure.
    for (int i = 0; i < 5; i++) push1(8'($urandom));
    ready_mode = 1;
    start_drain(5);
    wait_done(200);
    check_drain("toggle", 5);
    ready_mode = 0;
    tick();

    // Fewer words in the LIFO than requested.
    push2(8'hAA, 8'h55);
    start_drain(4);
`ifdef LIFO_POP_ADAPTER_WAIT_EN
    repeat (20) tick();
    chk("wait_busy", 32'(busy), 32'd1);
    chk("wait_words", 32'(got_d.size()), 32'd2);
    chk("wait_no_done", 32'(done_cnt), 32'd0);
    push2(8'h01, 8'h02);
    wait_done(200);
    begin
      logic [DW-1:0] wexp [4];
      wexp[0] = 8'h55;
      wexp[1] = 8'hAA;
      wexp[2] = 8'h02;
      wexp[3] = 8'h01;
      chk("wait_total", 32'(got_d.size()), 32'd4);
      for (int i = 0; i < 4; i++) begin
        if (i < got_d.size()) begin
          chk($sformatf("wait_data%0d", i), 32'(got_d[i]), 32'(wexp[i]));
          chk($sformatf("wait_last%0d", i), 32'(got_l[i]), 32'(i == 3));
        end
      end
    end
    chk("wait_short", 32'(last_short), 32'd0);
    ref_stk.delete();
`else
    wait_done(200);
    check_drain("underrun", 4);

    // Underrun with nothing at all to deliver.
    start_drain(3);
    wait_done(200);
    chk("empty_no_valid", 32'(first_valid), 32'hFFFF_FFFF);
    check_drain("empty", 3);
`endif

    // Zero-length request.
    start_drain(0);
    wait_done(50);
    chk("zero_done_cycle", 32'(done_cyc - t0), 32'd1);
    chk("zero_no_pop", 32'(pops), 32'd0);
    chk("zero_no_valid", 32'(first_valid), 32'hFFFF_FFFF);
    check_drain("zero", 0);

    // Second command while busy is dropped.
    for (int i = 0; i < 3; i++) push1(8'($urandom));
    start_drain(3);
    drain_start = 1'b1;
    drain_count = CW'(5);
    tick();
    drain_start = 1'b0;
    wait_done(200);
    repeat (8) tick();
    chk("ignore_idle", 32'(busy), 32'd0);
    check_drain("ignore", 3);

    // Reset in the middle of a drain with two words buffered.
    for (int i = 0; i < 4; i++) push1(8'($urandom));
    out_ready  = 1'b0;
    ready_mode = 3;
    start_drain(4);
    repeat (3) tick();
    chk("mid_pops", 32'(pops), 32'd2);
    chk("mid_valid", 32'(out_valid), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_valid", 32'(out_valid), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_rd_en", 32'(lifo_rd_en), 32'd0);
    chk("abort_done", 32'(drain_done), 32'd0);
    void'(ref_stk.pop_back());
    void'(ref_stk.pop_back());
    out_ready  = 1'b1;
    ready_mode = 0;
    start_drain(2);
    wait_done(200);
    chk("post_rst_accept", 32'(first_rden - t0), 32'd1);
    check_drain("post_rst", 2);

    // Randomised drains with random back-pressure.
    for (int it = 0; it < 8; it++) begin
      int np;
      int n;
      np = $urandom_range(0, 5);
      for (int j = 0; j < np; j++) push1(8'($urandom));
`ifdef LIFO_POP_ADAPTER_WAIT_EN
      n = $urandom_range(0, ref_stk.size());
`else
      n = $urandom_range(0, 7);
`endif
      ready_mode = 2;
      start_drain(n);
      wait_done(300);
      check_drain($sformatf("rnd%0d", it), n);
      ready_mode = 0;
      repeat (2) tick();
    end

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
`default_nettype wire
